// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the level-tracking FIFO.
// Used by m_fifo_lvl and fifo_wrap_ptr.
package fifo_pkg;

  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer counter with explicit wrap.
// Works for any DEPTH >= 2, power of two or not.
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/m_fifo_lvl.sv
// Single-clock FWFT FIFO with level, thresholds, sticky errors.
// Optional high-water mark on peak when FIFO_PEAK_EN is defined.
module m_fifo_lvl
  import fifo_pkg::*;
#(
  parameter int DWIDTH    = 40,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter int LW        = lvl_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wren,
  input  logic [DWIDTH-1:0] wd,
  input  logic              rden,
  output logic [DWIDTH-1:0] rd,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [LW-1:0]     level,
  output logic              overflow,
  output logic              underflow,
  output logic [LW-1:0]     peak
);

  localparam int PW = ptr_width(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     wrptr;
  logic [PW-1:0]     rdptr;
  logic [LW-1:0]     level_q;
  logic [LW-1:0]     level_nxt;
  logic              rden_eff;
  logic              push;
  logic              ovf_q;
  logic              udf_q;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));

  assign almost_full  = (level_q >= LW'(AF_THRESH));
  assign almost_empty = (level_q <= LW'(AE_THRESH));

  assign level     = level_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

  // clr blocks both strobes so pointers and memory stay put
  assign rden_eff = rden & ~empty & ~clr;
  assign push     = wren & (~full | rden_eff) & ~clr;

  assign rd = mem[rdptr];

  fifo_wrap_ptr #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_wrptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (push),
    .ptr   (wrptr)
  );

  fifo_wrap_ptr #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_rdptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (rden_eff),
    .ptr   (rdptr)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrptr] <= wd;
    end
  end

  always_comb begin
    level_nxt = level_q;
    unique case (1'b1)
      clr:                level_nxt = '0;
      push & ~rden_eff:   level_nxt = level_q + 1'b1;
      rden_eff & ~push:   level_nxt = level_q - 1'b1;
      default:            level_nxt = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (clr) begin
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      level_q <= level_nxt;
      if (wren & full & ~rden_eff) ovf_q <= 1'b1;
      if (rden & empty)            udf_q <= 1'b1;
    end
  end

`ifdef FIFO_PEAK_EN
  logic [LW-1:0] peak_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else if (clr) begin
      peak_q <= '0;
    end else if (level_nxt > peak_q) begin
      peak_q <= level_nxt;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

endmodule

// File: tb/tb_m_fifo_lvl.sv
// Directed plus random bench for m_fifo_lvl against a queue model.
// Peak expectations follow FIFO_PEAK_EN.
module tb_m_fifo_lvl;

  localparam int DW = 40;
  localparam int DP = 5;
  localparam int AF = 4;
  localparam int AE = 1;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          wren = 1'b0;
  logic [DW-1:0] wd = '0;
  logic          rden = 1'b0;
  logic [DW-1:0] rd;
  logic          full, empty, almost_full, almost_empty;
  logic [LW-1:0] level, peak;
  logic          overflow, underflow;

  m_fifo_lvl #(
    .DWIDTH    (DW),
    .DEPTH     (DP),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .wren         (wren),
    .wd           (wd),
    .rden         (rden),
    .rd           (rd),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow),
    .peak         (peak)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  bit            m_ov, m_uf;
  int            m_peak;
  int            vectors = 0;
  int            errs = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 0;
    m_uf = 0;
    m_peak = 0;
  endtask

  task automatic chk_all(input string tag);
    int n;
    int pk;
    n = q.size();
`ifdef FIFO_PEAK_EN
    pk = m_peak;
`else
    pk = 0;
`endif
    chk({tag, ".level"}, 64'(level), 64'(n));
    chk({tag, ".empty"}, 64'(empty), 64'(n == 0));
    chk({tag, ".full"}, 64'(full), 64'(n == DP));
    chk({tag, ".af"}, 64'(almost_full), 64'(n >= AF));
    chk({tag, ".ae"}, 64'(almost_empty), 64'(n <= AE));
    chk({tag, ".ovf"}, 64'(overflow), 64'(m_ov));
    chk({tag, ".udf"}, 64'(underflow), 64'(m_uf));
    chk({tag, ".peak"}, 64'(peak), 64'(pk));
    if (n > 0) chk({tag, ".rd"}, 64'(rd), 64'(q[0]));
  endtask

  // one clock: drive, model the cycle by the queue rules, check
  task automatic step(input string tag, input bit c, input bit w,
                      input logic [DW-1:0] d, input bit r);
    bit pop_ok, push_ok;
    clr = c;
    wren = w;
    wd = d;
    rden = r;
    @(posedge clk);
    if (c) begin
      q.delete();
      m_ov = 0;
      m_uf = 0;
      m_peak = 0;
    end else begin
      pop_ok = r && (q.size() > 0);
      push_ok = w && ((q.size() < DP) || pop_ok);
      if (w && !push_ok) m_ov = 1;
      if (r && q.size() == 0) m_uf = 1;
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back(d);
      if (q.size() > m_peak) m_peak = q.size();
    end
    #1;
    chk_all(tag);
    clr = 0;
    wren = 0;
    rden = 0;
  endtask

  task automatic pulse_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    #12;
    chk_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++)
      step("fill", 0, 1, 40'hA0 + 40'(i), 0);
    for (int i = 0; i < 5; i++)
      step("drain", 0, 0, '0, 1);

    step("pre1", 0, 1, 40'h100, 0);
    step("pre2", 0, 1, 40'h101, 0);
    for (int i = 0; i < 13; i++) begin
      step("wrap_w", 0, 1, 40'h200 + 40'(i), 0);
      step("wrap_r", 0, 0, '0, 1);
    end
    step("wrap_d1", 0, 0, '0, 1);
    step("wrap_d2", 0, 0, '0, 1);

    for (int i = 0; i < 5; i++)
      step("f2", 0, 1, 40'h300 + 40'(i), 0);
    step("full_wr", 0, 1, 40'h3FF, 1);
    step("full_ovf", 0, 1, 40'hDEAD, 0);
    for (int i = 0; i < 5; i++)
      step("f2_drain", 0, 0, '0, 1);

    step("empty_wr", 0, 1, 40'h4AA, 1);
    step("one_more", 0, 1, 40'h4AB, 0);

    for (int i = 0; i < 5; i++)
      step("f3", 0, 1, 40'h500 + 40'(i), 0);
    step("ovf3", 0, 1, 40'h5FF, 0);
    step("clr_wr", 1, 1, 40'h5EE, 0);
    step("post_clr", 0, 1, 40'h600, 0);
    step("post_clr_r", 0, 0, '0, 1);

    step("clr0", 1, 0, '0, 0);
    for (int i = 0; i < 3; i++)
      step("pk", 0, 1, 40'h700 + 40'(i), 0);
    pulse_reset("rst_mid");
    step("after_rst", 0, 1, 40'h800, 0);

    for (int i = 0; i < 1500; i++) begin
      bit c, w, r;
      int bias;
      bias = (i / 150) % 3;
      c = ($urandom_range(99) < 2);
      w = ($urandom_range(99) < (bias == 0 ? 75 : 45));
      r = ($urandom_range(99) < (bias == 2 ? 75 : 45));
      step("rand", c, w, {$urandom, $urandom}, r);
      if ($urandom_range(299) == 0) pulse_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/m_fifo_lvl.md
Name: m_fifo_lvl

Overview:
- Synchronous single-clock FIFO; generalised successor to the team's power-of-two strobe FIFO.
- Any DEPTH ≥ 2 is supported, including non-power-of-two depths.
- Adds an occupancy level, programmable almost-full/almost-empty flags, guarded push/pop with sticky overflow/underflow flags, and a synchronous clear.
- Sits between accelerator pipeline stages that need back-pressure thresholds rather than plain full/empty.

Parameters:
- DWIDTH, 40, data word width in bits.
- DEPTH, 4, number of entries; any integer ≥ 2.
- AF_THRESH, DEPTH-1, almost_full asserts when level ≥ AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 1, almost_empty asserts when level ≤ AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear; pointers, level and sticky flags go to 0.
- wren  in  1  push strobe.
- wd  in  DWIDTH  push data.
- rden  in  1  pop strobe.
- rd  out  DWIDTH  head data, first-word-fall-through, combinational from memory.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level ≥ AF_THRESH.
- almost_empty  out  1  level ≤ AE_THRESH.
- level  out  LW  current occupancy, where LW = $clog2(DEPTH+1).
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop was ignored.
- peak  out  LW  high-water mark (see Optional Feature).

Behaviour:
- Reset is asynchronous on rst_n low.
  - wrptr, rdptr and level go to 0.
  - Outputs at reset: empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, peak=0.
  - Memory is not reset; rd is undefined until the first push.
- Pointers are binary indices 0..DEPTH-1.
  - Increment with explicit wrap: DEPTH-1 → 0. No power-of-two masking.
- Full and empty are derived from level, not from pointer MSBs.
- Push accept rule: push = wren & (!full | rden_eff).
  - A write while full is accepted only if a valid pop happens in the same cycle.
- Pop accept rule: rden_eff = rden & !empty.
  - There is no write-to-read bypass. A pop while empty is ignored even if wren is high.
- An accepted push writes mem[wrptr] <= wd at the clock edge, then wrptr advances.
- An accepted pop advances rdptr.
- rd = mem[rdptr] at all times; it is valid whenever empty = 0.
- Push-to-visible latency: 1 cycle. After a push into an empty FIFO, empty deasserts and rd shows the word at the next edge.
- Level update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when push and pop are both accepted, or when neither is.
- All flags are combinational from registered level and state; there are no extra pipeline stages.
- overflow: set when wren & full & !rden_eff. The data is dropped and the state is unchanged.
- underflow: set when rden & empty. The pop is ignored.
- overflow and underflow stay set until clr or reset.
- clr has priority over wren and rden in the same cycle.
  - Pointers, level, overflow, underflow and peak go to 0.
  - The memory is untouched.
- Reset mid-operation: all queued data is logically discarded; state after release is identical to power-up.

Optional Feature:
- Macro: FIFO_PEAK_EN.
- Defined:
  - peak is a register updated each cycle to max(peak, next level).
  - It clears on reset or clr.
  - It is used for sizing studies.
- Undefined:
  - peak is tied to 0 and no register is inferred.
  - The port list is identical in both builds.

Decomposition:
- Shared package fifo_pkg holds:
  - function lvl_width(depth) = $clog2(depth+1);
  - function ptr_width(depth) = max(1, $clog2(depth)).
- One sub-module, fifo_wrap_ptr: a parametrised modulo-DEPTH pointer counter with inc, clr, async rst_n and a ptr output.
  - It is instantiated twice, once for wrptr and once for rdptr.

Test Plan:
- DEPTH=5, AF=4, AE=1. Push 0xA0..0xA4 →
  - level steps 1..5;
  - almost_empty drops when level reaches 2;
  - almost_full rises at level 4;
  - full=1 at level 5.
  - Then pop 5 → rd sequence A0..A4, empty=1, no flags set.
- Wrap at DEPTH=5: 13 push/pop pairs, staggered by 2 entries → data order preserved across three pointer wraps; level oscillates between 2 and 3.
- Full with wren & rden in the same cycle → push accepted, level stays 5, overflow=0, new word appears in order 5 pops later.
  - Full with wren only → overflow=1, level=5, contents unchanged.
- Empty with wren & rden in the same cycle → underflow=1, level=1, rd = wd of that cycle on the next cycle.
- clr asserted together with wren after overflow is set → level=0, empty=1, overflow=0, the write is discarded; next push is readable at rd.
- rst_n pulsed low mid-stream at level 3 → all outputs at reset values immediately.
  - With FIFO_PEAK_EN: peak=3 before the reset pulse and 0 after it.
